// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and defaults for the uart_tx arbiter.
// Optional macro UART_ARB_RR_EN selects round-robin arbitration.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    GAP,
    HOLD
  } arb_state_t;

  localparam int UART_ARB_GRANT_W   = 2;
  localparam int UART_ARB_BUSY_WAIT = 16;
  localparam int UART_ARB_IDLE_GAP  = 0;

endpackage

// File: rtl/uart_arb_pick.sv
// uart_arb_pick: combinational winner select over the request vector.
// UART_ARB_RR_EN: search from ptr with wrap; else lowest index wins.
module uart_arb_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [UART_ARB_GRANT_W-1:0] ptr,
  output logic [UART_ARB_GRANT_W-1:0] win,
  output logic                        any
);

  assign any = |req;

`ifdef UART_ARB_RR_EN
  int   idx;
  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        win   = UART_ARB_GRANT_W'(idx);
        found = 1'b1;
      end
    end
  end
`else
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) win = UART_ARB_GRANT_W'(k);
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among requesters, packet at a time.
// Macro UART_ARB_RR_EN enables round-robin; default is fixed priority.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int BUSY_WAIT = UART_ARB_BUSY_WAIT,
  parameter int IDLE_GAP  = UART_ARB_IDLE_GAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [1:0]           grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  localparam int GW = UART_ARB_GRANT_W;
  localparam int CW = $clog2(BUSY_WAIT + 1);
  localparam logic [CW-1:0] BW_LAST  = CW'(BUSY_WAIT - 1);
  localparam logic [7:0]    GAP_LAST = 8'(IDLE_GAP - 1);

  arb_state_t    state, nxt;
  logic [GW-1:0] owner, win, ptr, sel;
  logic          any, last_f, res, to_hit;
  logic [CW-1:0] cnt;
  logic [7:0]    gcnt;
  logic [3:0]    v4, l4;
  logic [7:0]    dat [4];

  assign v4 = 4'(req_valid);
  assign l4 = 4'(req_last);

  for (genvar i = 0; i < 4; i++) begin : g_dat
    if (i < NUM_REQ) begin : g_on
      assign dat[i] = req_data[8*i +: 8];
    end else begin : g_off
      assign dat[i] = '0;
    end
  end

`ifdef UART_ARB_RR_EN
  logic [GW-1:0] rr_ptr;
  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  uart_arb_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .win(win),
    .any(any)
  );

  // the byte is captured on entry to SEND so it is valid with tx_start
  assign sel      = (state == IDLE) ? win : owner;
  assign tx_start = (state == SEND);
  assign grant_id = owner;
  assign to_hit   = (state == WAIT_HI) && !tx_busy
                    && (cnt == BW_LAST);
  assign timeout_err = to_hit;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == SEND) && (owner == GW'(i));
    end
  end

  always_comb begin
    nxt = state;
    res = 1'b0;
    unique case (state)
      IDLE:    if (any && !tx_busy) nxt = SEND;
      SEND:    nxt = WAIT_HI;
      WAIT_HI: if (tx_busy || cnt == BW_LAST) nxt = WAIT_LO;
      WAIT_LO: begin
        if (!tx_busy) begin
          if (IDLE_GAP > 0) nxt = GAP;
          else              res = 1'b1;
        end
      end
      GAP:     if (gcnt == GAP_LAST) res = 1'b1;
      HOLD:    if (v4[owner]) nxt = SEND;
      default: nxt = IDLE;
    endcase
    if (res) begin
      if (last_f)         nxt = IDLE;
      else if (v4[owner]) nxt = SEND;
      else                nxt = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      arb_busy <= 1'b0;
      last_f   <= 1'b0;
      tx_data  <= '0;
      cnt      <= '0;
      gcnt     <= '0;
`ifdef UART_ARB_RR_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == SEND) begin
        owner    <= win;
        arb_busy <= 1'b1;
      end
      if (nxt == SEND) tx_data <= dat[sel];
      if (state == SEND) begin
        last_f <= l4[owner];
        cnt    <= '0;
      end
      if (state == WAIT_HI) cnt <= cnt + 1'b1;
      if (state == WAIT_LO) gcnt <= '0;
      if (state == GAP) gcnt <= gcnt + 8'd1;
      if (res && last_f) begin
        owner    <= '0;
        arb_busy <= 1'b0;
`ifdef UART_ARB_RR_EN
        rr_ptr <= (owner == GW'(NUM_REQ - 1))
                  ? '0 : owner + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with packet-level arbitration model.
// Honours UART_ARB_RR_EN the same way as the design.
module tb_uart_tx_arbiter;

  localparam int N        = 3;
  localparam int BW       = 16;
  localparam int BUSY_LEN = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   rv = '0;
  logic [N-1:0]   rl = '0;
  logic [N*8-1:0] rd = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start, tx_busy, arb_busy, timeout_err;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .BUSY_WAIT(BW),
    .IDLE_GAP(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(rv),
    .req_data(rd),
    .req_last(rl),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .arb_busy(arb_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q [N][$];
  int   win_q[$];
  int   gseq[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, t_start = 0, n_start = 0, n_to = 0;
  int   mptr = 0, cur = 0, mg, mw;
  int   rdy_cnt [N];
  exp_t me;
  bit   in_pkt = 0, tie0 = 0;
  bit   ok_a, ok_b;
  logic busy_m;
  int   bcnt;

  assign tx_busy = busy_m;

  task automatic chk(bit ok, string nm, int act, int expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  function automatic int model_pick(logic [N-1:0] v);
`ifdef UART_ARB_RR_EN
    for (int k = 0; k < N; k++)
      if (v[(mptr + k) % N]) return (mptr + k) % N;
`else
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
`endif
    return -1;
  endfunction

  // uart_tx model: busy rises the cycle after tx_start for BUSY_LEN cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0;
      bcnt   <= 0;
    end else if (tie0) begin
      busy_m <= 1'b0;
    end else if (tx_start) begin
      busy_m <= 1'b1;
      bcnt   <= BUSY_LEN;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) busy_m <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!arb_busy && (|rv) && !tx_busy)
        win_q.push_back(model_pick(rv));
      for (int i = 0; i < N; i++)
        if (req_ready[i]) rdy_cnt[i]++;
      if (!tx_start && req_ready != '0)
        chk(0, "ready_without_start", int'(req_ready), 0);
      if (tx_start) begin
        mg = int'(grant_id);
        n_start++;
        t_start = cyc;
        chk(req_ready == N'(1 << mg), "ready_onehot",
            int'(req_ready), 1 << mg);
        if (!in_pkt) begin
          gseq.push_back(mg);
          if (win_q.size() == 0) begin
            chk(0, "winner_unexpected", mg, -1);
          end else begin
            mw = win_q.pop_front();
            chk(mg == mw, "winner", mg, mw);
          end
          cur    = mg;
          in_pkt = 1;
        end else begin
          chk(mg == cur, "packet_contiguous", mg, cur);
        end
        if (mg >= N || exp_q[mg].size() == 0) begin
          chk(0, "byte_unexpected", mg, -1);
        end else begin
          me = exp_q[mg].pop_front();
          chk(tx_data == me.d, "tx_data", int'(tx_data), int'(me.d));
          if (me.l) begin
            in_pkt = 0;
            mptr   = (mg + 1) % N;
          end
        end
      end
      if (timeout_err) begin
        n_to++;
        chk(tie0, "timeout_allowed", 1, int'(tie0));
        chk(cyc - t_start == BW, "timeout_delay", cyc - t_start, BW);
      end
    end
  end

  task automatic drive_byte(int r, logic [7:0] d, logic l,
                            int gap, output bit ok);
    exp_t e;
    ok = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    if (!rst_n) return;
    rv[r]        = 1'b1;
    rd[8*r +: 8] = d;
    rl[r]        = l;
    e.d = d;
    e.l = l;
    exp_q[r].push_back(e);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!rst_n) begin
        rv[r] = 1'b0;
        rl[r] = 1'b0;
        return;
      end
      if (req_ready[r]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(0, "ready_timeout", r, 1);
    @(posedge clk);
    #1;
    rv[r] = 1'b0;
    rl[r] = 1'b0;
  endtask

  task automatic drive_pkt(int r, int len, int maxgap);
    bit ok;
    int g;
    for (int b = 0; b < len; b++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      drive_byte(r, 8'($urandom_range(0, 255)), b == len - 1, g, ok);
      if (!ok) return;
    end
  endtask

  task automatic rand_req(int r);
    repeat (4) begin
      repeat ($urandom_range(0, 20)) begin
        @(posedge clk);
        #1;
      end
      drive_pkt(r, int'($urandom_range(1, 3)), 3);
    end
  endtask

  task automatic wait_idle(string nm);
    bit done = 0;
    int pend;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      pend = win_q.size();
      for (int i = 0; i < N; i++) pend += exp_q[i].size();
      if (!arb_busy && rv == '0 && !tx_busy && pend == 0) begin
        done = 1;
        break;
      end
    end
    chk(done, nm, int'(done), 1);
  endtask

  task automatic chk_zero(string nm);
    chk(tx_start == 1'b0, {nm, "_tx_start"}, int'(tx_start), 0);
    chk(req_ready == '0, {nm, "_req_ready"}, int'(req_ready), 0);
    chk(arb_busy == 1'b0, {nm, "_arb_busy"}, int'(arb_busy), 0);
    chk(grant_id == 2'd0, {nm, "_grant_id"}, int'(grant_id), 0);
    chk(timeout_err == 1'b0, {nm, "_timeout"}, int'(timeout_err), 0);
    chk(tx_data == 8'd0, {nm, "_tx_data"}, int'(tx_data), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rc, gs, ns, nt;
    bit hold_ok, seen;
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rc = rdy_cnt[1];
    fork
      begin
        drive_byte(1, 8'h41, 1'b0, 0, ok_a);
        drive_byte(1, 8'h42, 1'b1, 0, ok_a);
      end
      begin
        @(negedge clk);
        chk(!tx_start, "latency_T", int'(tx_start), 0);
        @(negedge clk);
        chk(tx_start, "latency_T1", int'(tx_start), 1);
        chk(tx_data == 8'h41, "first_byte", int'(tx_data), 'h41);
      end
    join
    wait_idle("single_release");
    chk(rdy_cnt[1] - rc == 2, "single_ready_pulses", rdy_cnt[1] - rc, 2);

    fork
      drive_pkt(0, 3, 0);
      drive_pkt(2, 3, 0);
    join
    wait_idle("contention_release");

    gs = gseq.size();
    fork
      repeat (4) drive_pkt(0, 1, 0);
      repeat (4) drive_pkt(1, 1, 0);
    join
    wait_idle("stream_release");
    chk(gseq.size() - gs == 8, "stream_packets", gseq.size() - gs, 8);
`ifdef UART_ARB_RR_EN
    for (int k = gs; k + 1 < gseq.size(); k++)
      chk(gseq[k] != gseq[k+1], "rr_alternate", gseq[k+1], 1 - gseq[k]);
`endif

    drive_byte(0, 8'hA0, 1'b0, 0, ok_a);
    fork
      drive_byte(1, 8'h55, 1'b1, 0, ok_b);
      begin
        ns      = n_start;
        hold_ok = 1;
        repeat (50) begin
          @(negedge clk);
          if (grant_id != 2'd0 || !arb_busy) hold_ok = 0;
        end
        chk(hold_ok, "hold_grant_locked", int'(hold_ok), 1);
        chk(n_start == ns, "hold_no_start", n_start - ns, 0);
        @(posedge clk);
        #1;
        drive_byte(0, 8'hB1, 1'b1, 0, ok_a);
      end
    join
    wait_idle("hold_release");

    tie0 = 1;
    nt   = n_to;
    drive_pkt(0, 2, 0);
    wait_idle("timeout_release");
    chk(n_to - nt == 2, "timeout_count", n_to - nt, 2);
    tie0 = 0;

    fork
      rand_req(0);
      rand_req(1);
      rand_req(2);
    join
    wait_idle("random_release");

    fork
      drive_pkt(2, 3, 0);
      begin
        seen = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (tx_busy) begin
            seen = 1;
            break;
          end
        end
        chk(seen, "busy_before_reset", int'(seen), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
      end
    join
    for (int i = 0; i < N; i++) exp_q[i].delete();
    win_q.delete();
    in_pkt = 0;
    mptr   = 0;
    rv     = '0;
    rl     = '0;
    rst_n  = 1'b1;
    @(negedge clk);
    chk(!arb_busy, "post_reset_idle", int'(arb_busy), 0);
    @(posedge clk);
    #1;
    drive_pkt(1, 2, 0);
    wait_idle("post_reset_packet");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
